// File: rtl/bsg_mcl_axil_pkg.sv
// Shared definitions for the MCL-over-AXI-lite adapter: AXI-lite bus structs,
// remote AXI-Stream FIFO register offsets, FSM state and sub-op encodings.
package bsg_mcl_axil_pkg;

    typedef struct packed {
        logic [31:0] awaddr;
        logic [2:0]  awprot;
        logic        awvalid;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        wvalid;
        logic        bready;
        logic [31:0] araddr;
        logic [2:0]  arprot;
        logic        arvalid;
        logic        rready;
    } bsg_axil_mosi_bus_s;

    typedef struct packed {
        logic        awready;
        logic        wready;
        logic [1:0]  bresp;
        logic        bvalid;
        logic        arready;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        logic        rvalid;
    } bsg_axil_miso_bus_s;

    localparam int axil_mosi_bus_width_gp = $bits(bsg_axil_mosi_bus_s);
    localparam int axil_miso_bus_width_gp = $bits(bsg_axil_miso_bus_s);

    localparam logic [1:0] axi_resp_okay_gp = 2'b00;

    localparam logic [31:0] tdfd_offset_gp = 32'h10;
    localparam logic [31:0] tlr_offset_gp  = 32'h14;
    localparam logic [31:0] rdfo_offset_gp = 32'h1C;
    localparam logic [31:0] rdfd_offset_gp = 32'h20;
    localparam logic [31:0] rlr_offset_gp  = 32'h24;

    typedef enum logic [2:0] {
        IDLE,
        WADDR,
        WRESP,
        RADDR,
        RDATA
    } mcl_state_e;

    typedef enum logic [2:0] {
        TX_WORD,
        TX_LEN,
        RX_POLL,
        RX_LEN,
        RX_WORD
    } mcl_op_e;

endpackage

// File: rtl/m_axil_mcl_adapter_if.sv
// AXI-lite request/response channel bundle used to wire the adapter to a slave.
interface m_axil_mcl_adapter_if;
    import bsg_mcl_axil_pkg::*;

    bsg_axil_mosi_bus_s mosi;
    bsg_axil_miso_bus_s miso;

    modport master (output mosi, input  miso);
    modport slave  (input  mosi, output miso);

endinterface

// File: rtl/m_axil_mcl_wordbuf.sv
// Packet-wide shift buffer: parallel load with 32-bit shift-out toward the LSW,
// or 32-bit shift-in at the MSW end with parallel read (LSW arrives first).
module m_axil_mcl_wordbuf #(
    parameter int width_p = 128
) (
    input  logic               clk_i,
    input  logic               load_i,
    input  logic [width_p-1:0] data_i,
    input  logic               shift_out_i,
    input  logic               shift_in_i,
    input  logic [31:0]        word_i,
    output logic [width_p-1:0] data_o
);

    // NOTE: pure datapath storage has no reset; the adapter's valid/full flags
    // decide when its contents mean anything.
    always_ff @(posedge clk_i) begin
        if (load_i) begin
            data_o <= data_i;
        end else if (shift_out_i) begin
            data_o <= {32'b0, data_o[width_p-1:32]};
        end else if (shift_in_i) begin
            data_o <= {word_i, data_o[width_p-1:32]};
        end
    end

endmodule

// File: rtl/m_axil_mcl_adapter.sv
// Bridges an MCL packet valid/ready pair onto AXI-lite accesses of a remote
// AXI-Stream FIFO register block, with one transaction outstanding at a time.
module m_axil_mcl_adapter
    import bsg_mcl_axil_pkg::*;
#(
    parameter int          mcl_width_p            = 128,
    parameter logic [31:0] base_addr_p            = 32'h8000_0000,
    parameter int          axil_mosi_bus_width_lp = axil_mosi_bus_width_gp,
    parameter int          axil_miso_bus_width_lp = axil_miso_bus_width_gp
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    output logic [axil_mosi_bus_width_lp-1:0] m_axil_mcl_bus_o,
    input  logic [axil_miso_bus_width_lp-1:0] m_axil_mcl_bus_i,
    input  logic                              mcl_v_i,
    input  logic [mcl_width_p-1:0]            mcl_data_i,
    output logic                              mcl_r_o,
    output logic                              mcl_v_o,
    output logic [mcl_width_p-1:0]            mcl_data_o,
    input  logic                              mcl_r_i,
    output logic                              error_o
);

    localparam int                      words_lp     = mcl_width_p / 32;
    localparam int                      cnt_width_lp = $clog2(words_lp + 1);
    localparam logic [cnt_width_lp-1:0] last_word_lp = cnt_width_lp'(words_lp - 1);
    localparam logic [31:0]             words32_lp   = 32'(words_lp);
    localparam logic [31:0]             len_bytes_lp = 32'(words_lp * 4);

    bsg_axil_mosi_bus_s mosi;
    bsg_axil_miso_bus_s miso;

    assign miso             = m_axil_mcl_bus_i;
    assign m_axil_mcl_bus_o = mosi;

    mcl_state_e              state_r;
    mcl_op_e                 op_r;
    logic [cnt_width_lp-1:0] cnt_r;
    logic                    tx_full_r;
    logic                    last_tx_r;
    logic                    awvalid_r, wvalid_r, bready_r, arvalid_r, rready_r;
    logic [31:0]             awaddr_r, wdata_r, araddr_r;

    logic [mcl_width_p-1:0]  tx_data;
    logic                    tx_fire, tx_done, tx_full_n, tx_shift, rx_shift, rx_elig;
    logic [31:0]             poll_words;

    assign tx_fire    = mcl_v_i & mcl_r_o;
    assign tx_done    = (state_r == WRESP) & (op_r == TX_LEN) & miso.bvalid;
    assign tx_full_n  = tx_fire | (tx_full_r & ~tx_done);
    assign tx_shift   = (state_r == WADDR) & (op_r == TX_WORD) & wvalid_r & miso.wready;
    assign rx_shift   = (state_r == RDATA) & (op_r == RX_WORD) & miso.rvalid;
    assign rx_elig    = ~mcl_v_o;
    assign poll_words = (miso.rresp == axi_resp_okay_gp) ? miso.rdata : 32'b0;

    m_axil_mcl_wordbuf #(.width_p(mcl_width_p)) tx_buf (
        .clk_i      (clk_i),
        .load_i     (tx_fire),
        .data_i     (mcl_data_i),
        .shift_out_i(tx_shift),
        .shift_in_i (1'b0),
        .word_i     (32'b0),
        .data_o     (tx_data)
    );

    m_axil_mcl_wordbuf #(.width_p(mcl_width_p)) rx_buf (
        .clk_i      (clk_i),
        .load_i     (1'b0),
        .data_i     ('0),
        .shift_out_i(1'b0),
        .shift_in_i (rx_shift),
        .word_i     (miso.rdata),
        .data_o     (mcl_data_o)
    );

    // Only the low word of the TX buffer is ever presented on wdata.
    logic unused_tx_hi;
    assign unused_tx_hi = ^tx_data[mcl_width_p-1:32];

    always_comb begin
        // NOTE: assign the whole struct a default first so every field is driven
        // on every path and no latch is inferred.
        mosi         = '0;
        mosi.awaddr  = awaddr_r;
        mosi.awvalid = awvalid_r;
        mosi.wdata   = wdata_r;
        mosi.wstrb   = 4'hF;
        mosi.wvalid  = wvalid_r;
        mosi.bready  = bready_r;
        mosi.araddr  = araddr_r;
        mosi.arvalid = arvalid_r;
        mosi.rready  = rready_r;
    end

    // NOTE: all state is updated with non-blocking assignments so every branch
    // sees the pre-edge values of the other registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r   <= IDLE;
            op_r      <= TX_WORD;
            cnt_r     <= '0;
            tx_full_r <= 1'b0;
            last_tx_r <= 1'b0;
            mcl_r_o   <= 1'b0;
            mcl_v_o   <= 1'b0;
            error_o   <= 1'b0;
            awvalid_r <= 1'b0;
            wvalid_r  <= 1'b0;
            bready_r  <= 1'b0;
            arvalid_r <= 1'b0;
            rready_r  <= 1'b0;
            awaddr_r  <= '0;
            wdata_r   <= '0;
            araddr_r  <= '0;
        end else begin
            tx_full_r <= tx_full_n;
            mcl_r_o   <= ~tx_full_n;
            if (mcl_v_o & mcl_r_i) mcl_v_o <= 1'b0;

            unique case (state_r)
                IDLE: begin
                    // On a tie, serve whichever side did not complete last.
                    if (tx_full_r && (!rx_elig || !last_tx_r)) begin
                        op_r      <= TX_WORD;
                        cnt_r     <= '0;
                        awaddr_r  <= base_addr_p + tdfd_offset_gp;
                        wdata_r   <= tx_data[31:0];
                        awvalid_r <= 1'b1;
                        wvalid_r  <= 1'b1;
                        state_r   <= WADDR;
                    end else if (rx_elig) begin
                        op_r      <= RX_POLL;
                        cnt_r     <= '0;
                        araddr_r  <= base_addr_p + rdfo_offset_gp;
                        arvalid_r <= 1'b1;
                        state_r   <= RADDR;
                    end
                end
                WADDR: begin
                    if (miso.awready) awvalid_r <= 1'b0;
                    if (miso.wready)  wvalid_r  <= 1'b0;
                    if ((!awvalid_r || miso.awready) && (!wvalid_r || miso.wready)) begin
                        bready_r <= 1'b1;
                        state_r  <= WRESP;
                    end
                end
                WRESP: begin
                    if (miso.bvalid) begin
                        bready_r <= 1'b0;
                        if (miso.bresp != axi_resp_okay_gp) error_o <= 1'b1;
                        if (op_r == TX_WORD) begin
                            awvalid_r <= 1'b1;
                            wvalid_r  <= 1'b1;
                            state_r   <= WADDR;
                            if (cnt_r == last_word_lp) begin
                                op_r     <= TX_LEN;
                                cnt_r    <= '0;
                                awaddr_r <= base_addr_p + tlr_offset_gp;
                                wdata_r  <= len_bytes_lp;
                            end else begin
                                cnt_r    <= cnt_r + 1'b1;
                                wdata_r  <= tx_data[31:0];
                            end
                        end else begin
                            last_tx_r <= 1'b1;
                            state_r   <= IDLE;
                        end
                    end
                end
                RADDR: begin
                    if (miso.arready) begin
                        arvalid_r <= 1'b0;
                        rready_r  <= 1'b1;
                        state_r   <= RDATA;
                    end
                end
                RDATA: begin
                    if (miso.rvalid) begin
                        rready_r <= 1'b0;
                        if (miso.rresp != axi_resp_okay_gp) error_o <= 1'b1;
                        unique case (op_r)
                            RX_POLL: begin
                                if (poll_words < words32_lp) begin
                                    last_tx_r <= 1'b0;
                                    state_r   <= IDLE;
                                end else begin
                                    op_r      <= RX_LEN;
                                    araddr_r  <= base_addr_p + rlr_offset_gp;
                                    arvalid_r <= 1'b1;
                                    state_r   <= RADDR;
                                end
                            end
                            RX_LEN: begin
                                op_r      <= RX_WORD;
                                cnt_r     <= '0;
                                araddr_r  <= base_addr_p + rdfd_offset_gp;
                                arvalid_r <= 1'b1;
                                state_r   <= RADDR;
                            end
                            RX_WORD: begin
                                if (cnt_r == last_word_lp) begin
                                    cnt_r     <= '0;
                                    mcl_v_o   <= 1'b1;
                                    last_tx_r <= 1'b0;
                                    state_r   <= IDLE;
                                end else begin
                                    cnt_r     <= cnt_r + 1'b1;
                                    arvalid_r <= 1'b1;
                                    state_r   <= RADDR;
                                end
                            end
                            default: state_r <= IDLE;
                        endcase
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_m_axil_mcl_adapter.sv
// Directed bench for m_axil_mcl_adapter (128-bit packets, base 0x80000000),
// playing the AXI-lite slave by hand in one linear stimulus sequence.
module tb_m_axil_mcl_adapter;
    import bsg_mcl_axil_pkg::*;

    localparam logic [31:0] a_tdfd = 32'h8000_0010;
    localparam logic [31:0] a_tlr  = 32'h8000_0014;
    localparam logic [31:0] a_rdfo = 32'h8000_001C;
    localparam logic [31:0] a_rdfd = 32'h8000_0020;
    localparam logic [31:0] a_rlr  = 32'h8000_0024;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         mcl_v_i, mcl_r_o, mcl_v_o, mcl_r_i, error_o;
    logic [127:0] mcl_data_i, mcl_data_o;
    int           n_assert = 0;
    int           n_fail = 0;

    m_axil_mcl_adapter_if axil_if ();

    m_axil_mcl_adapter #(
        .mcl_width_p(128),
        .base_addr_p(32'h8000_0000)
    ) dut (
        .clk_i           (clk),
        .reset_i         (reset),
        .m_axil_mcl_bus_o(axil_if.mosi),
        .m_axil_mcl_bus_i(axil_if.miso),
        .mcl_v_i         (mcl_v_i),
        .mcl_data_i      (mcl_data_i),
        .mcl_r_o         (mcl_r_o),
        .mcl_v_o         (mcl_v_o),
        .mcl_data_o      (mcl_data_o),
        .mcl_r_i         (mcl_r_i),
        .error_o         (error_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic send_tx(input string tag, input logic [127:0] d);
        int n = 0;
        while (mcl_r_o !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        chk({tag, "_mcl_r"}, mcl_r_o, 1'b1);
        mcl_v_i    = 1'b1;
        mcl_data_i = d;
        @(negedge clk);
        mcl_v_i = 1'b0;
        chk({tag, "_r_drop"}, mcl_r_o, 1'b0);
    endtask

    task automatic serve_read(input string tag, input logic [31:0] addr,
                              input logic [31:0] data, input logic [1:0] resp);
        int n = 0;
        while (axil_if.mosi.arvalid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        chk({tag, "_arvalid"}, axil_if.mosi.arvalid, 1'b1);
        chk({tag, "_araddr"}, axil_if.mosi.araddr, addr);
        axil_if.miso.arready = 1'b1;
        @(negedge clk);
        axil_if.miso.arready = 1'b0;
        chk({tag, "_arvalid_drop"}, axil_if.mosi.arvalid, 1'b0);
        chk({tag, "_rready"}, axil_if.mosi.rready, 1'b1);
        axil_if.miso.rvalid = 1'b1;
        axil_if.miso.rdata  = data;
        axil_if.miso.rresp  = resp;
        @(negedge clk);
        axil_if.miso.rvalid = 1'b0;
        axil_if.miso.rdata  = '0;
        axil_if.miso.rresp  = 2'b00;
    endtask

    task automatic serve_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                               input logic [1:0] resp, input int aw_delay);
        int n = 0;
        while (axil_if.mosi.awvalid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        chk({tag, "_awvalid"}, axil_if.mosi.awvalid, 1'b1);
        chk({tag, "_awaddr"}, axil_if.mosi.awaddr, addr);
        chk({tag, "_wvalid"}, axil_if.mosi.wvalid, 1'b1);
        chk({tag, "_wdata"}, axil_if.mosi.wdata, data);
        chk({tag, "_wstrb"}, axil_if.mosi.wstrb, 4'hF);
        axil_if.miso.wready  = 1'b1;
        axil_if.miso.awready = (aw_delay == 0);
        @(negedge clk);
        axil_if.miso.wready = 1'b0;
        if (aw_delay > 0) begin
            chk({tag, "_wvalid_low"}, axil_if.mosi.wvalid, 1'b0);
            chk({tag, "_awvalid_held"}, axil_if.mosi.awvalid, 1'b1);
            repeat (aw_delay - 1) @(negedge clk);
            chk({tag, "_awvalid_still"}, axil_if.mosi.awvalid, 1'b1);
            chk({tag, "_awaddr_stable"}, axil_if.mosi.awaddr, addr);
            chk({tag, "_bready_early"}, axil_if.mosi.bready, 1'b0);
            axil_if.miso.awready = 1'b1;
            @(negedge clk);
        end
        axil_if.miso.awready = 1'b0;
        chk({tag, "_aw_done"}, axil_if.mosi.awvalid, 1'b0);
        chk({tag, "_w_done"}, axil_if.mosi.wvalid, 1'b0);
        chk({tag, "_bready"}, axil_if.mosi.bready, 1'b1);
        axil_if.miso.bvalid = 1'b1;
        axil_if.miso.bresp  = resp;
        @(negedge clk);
        axil_if.miso.bvalid = 1'b0;
        axil_if.miso.bresp  = 2'b00;
    endtask

    task automatic tx_writes(input string tag, input logic [127:0] d,
                             input int bad_word, input int aw_delay);
        for (int k = 0; k < 4; k++) begin
            serve_write($sformatf("%s_w%0d", tag, k), a_tdfd, d[32*k +: 32],
                        (k == bad_word) ? 2'b10 : 2'b00, (k == 0) ? aw_delay : 0);
            if (k == bad_word) chk({tag, "_err_set"}, error_o, 1'b1);
        end
        serve_write({tag, "_tlr"}, a_tlr, 32'h10, 2'b00, 0);
    endtask

    initial begin
        axil_if.miso = '0;
        mcl_v_i      = 1'b0;
        mcl_data_i   = '0;
        mcl_r_i      = 1'b0;
        reset        = 1'b1;
        repeat (2) @(negedge clk);

        chk("rst_mcl_r", mcl_r_o, 1'b0);
        chk("rst_mcl_v", mcl_v_o, 1'b0);
        chk("rst_error", error_o, 1'b0);
        chk("rst_awvalid", axil_if.mosi.awvalid, 1'b0);
        chk("rst_wvalid", axil_if.mosi.wvalid, 1'b0);
        chk("rst_arvalid", axil_if.mosi.arvalid, 1'b0);
        chk("rst_bready", axil_if.mosi.bready, 1'b0);
        chk("rst_rready", axil_if.mosi.rready, 1'b0);

        reset = 1'b0;
        @(negedge clk);
        chk("mcl_r_first_edge", mcl_r_o, 1'b1);

        // Basic TX: the first poll is already under way when the packet lands.
        send_tx("tx0", 128'h44444444_33333333_22222222_11111111);
        serve_read("poll0", a_rdfo, 32'd0, 2'b00);
        tx_writes("tx0", 128'h44444444_33333333_22222222_11111111, -1, 0);
        chk("tx0_r_back", mcl_r_o, 1'b1);

        // RX: empty poll, then a four-word packet.
        serve_read("poll1", a_rdfo, 32'd0, 2'b00);
        serve_read("poll2", a_rdfo, 32'd4, 2'b00);
        serve_read("rlr", a_rlr, 32'h10, 2'b00);
        serve_read("rd0", a_rdfd, 32'hAAAA0001, 2'b00);
        serve_read("rd1", a_rdfd, 32'hBBBB0002, 2'b00);
        serve_read("rd2", a_rdfd, 32'hCCCC0003, 2'b00);
        serve_read("rd3", a_rdfd, 32'hDDDD0004, 2'b00);
        chk("rx_valid", mcl_v_o, 1'b1);
        chk("rx_data", mcl_data_o, 128'hDDDD0004_CCCC0003_BBBB0002_AAAA0001);

        // RX register held full: no polling, TX still goes, with a slow awready
        // on the first word and an error response on the second.
        repeat (4) begin
            @(negedge clk);
            chk("rx_full_no_ar", axil_if.mosi.arvalid, 1'b0);
        end
        send_tx("tx1", 128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A);
        tx_writes("tx1", 128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A, 1, 5);
        chk("tx1_r_back", mcl_r_o, 1'b1);
        repeat (3) @(negedge clk);
        chk("rx_full_no_ar2", axil_if.mosi.arvalid, 1'b0);
        chk("rx_still_valid", mcl_v_o, 1'b1);
        chk("rx_data_held", mcl_data_o, 128'hDDDD0004_CCCC0003_BBBB0002_AAAA0001);
        chk("err_sticky", error_o, 1'b1);

        mcl_r_i = 1'b1;
        @(negedge clk);
        chk("rx_consumed", mcl_v_o, 1'b0);

        // Alternation with both sides wanting service.
        send_tx("tx2", 128'h13131313_12121212_11111110_10101010);
        serve_read("alt_rx0", a_rdfo, 32'd0, 2'b00);
        tx_writes("alt_tx0", 128'h13131313_12121212_11111110_10101010, -1, 0);
        send_tx("tx3", 128'h23232323_22222222_21212121_20202020);
        serve_read("alt_rx1", a_rdfo, 32'd3, 2'b00);
        tx_writes("alt_tx1", 128'h23232323_22222222_21212121_20202020, -1, 0);
        chk("err_sticky2", error_o, 1'b1);

        // Reset asserted while a poll read is in its data phase.
        serve_read("pre_rst_dummy", a_rdfo, 32'd0, 2'b00);
        begin
            int n = 0;
            while (axil_if.mosi.arvalid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        end
        chk("rst_ar_seen", axil_if.mosi.arvalid, 1'b1);
        axil_if.miso.arready = 1'b1;
        @(negedge clk);
        axil_if.miso.arready = 1'b0;
        chk("rst_in_rdata", axil_if.mosi.rready, 1'b1);
        reset = 1'b1;
        #1;
        chk("mid_rst_rready", axil_if.mosi.rready, 1'b0);
        chk("mid_rst_arvalid", axil_if.mosi.arvalid, 1'b0);
        chk("mid_rst_awvalid", axil_if.mosi.awvalid, 1'b0);
        chk("mid_rst_wvalid", axil_if.mosi.wvalid, 1'b0);
        chk("mid_rst_bready", axil_if.mosi.bready, 1'b0);
        chk("mid_rst_mcl_v", mcl_v_o, 1'b0);
        chk("mid_rst_mcl_r", mcl_r_o, 1'b0);
        chk("mid_rst_error", error_o, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_mcl_r", mcl_r_o, 1'b1);
        chk("post_rst_mcl_v", mcl_v_o, 1'b0);

        send_tx("tx4", 128'h87654321_0FEDCBA9_13579BDF_2468ACE0);
        serve_read("post_poll", a_rdfo, 32'd0, 2'b00);
        tx_writes("post_tx", 128'h87654321_0FEDCBA9_13579BDF_2468ACE0, -1, 0);
        chk("post_mcl_v", mcl_v_o, 1'b0);
        chk("post_error", error_o, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/m_axil_mcl_adapter.md
M_AXIL_MCL_ADAPTER -- requirements
Module: m_axil_mcl_adapter

Interface
REQ-001 SHALL have parameter mcl_width_p, default "inv", giving the MCL packet width in bits; it must be a multiple of 32 and at least 64.
REQ-002 SHALL have parameter base_addr_p, default 32'h80000000, giving the base address of the remote AXI-Stream FIFO register block.
REQ-003 SHALL have parameter axil_mosi_bus_width_lp, default `bsg_axil_mosi_bus_width(1).
REQ-004 SHALL have parameter axil_miso_bus_width_lp, default `bsg_axil_miso_bus_width(1).
REQ-005 SHALL have ports, in this order:
  clk_i  in  1  sole clock
  reset_i  in  1  asynchronous, active-high reset
  m_axil_mcl_bus_o  out  axil_mosi_bus_width_lp  AXI-lite master request channels
  m_axil_mcl_bus_i  in  axil_miso_bus_width_lp  AXI-lite master response channels
  mcl_v_i  in  1  TX packet valid
  mcl_data_i  in  mcl_width_p  TX packet
  mcl_r_o  out  1  TX ready
  mcl_v_o  out  1  RX packet valid
  mcl_data_o  out  mcl_width_p  RX packet
  mcl_r_i  in  1  RX ready
  error_o  out  1  sticky error on a non-OKAY response

Function
REQ-006 SHALL define W = mcl_width_p/32 as the number of words per packet.
REQ-007 SHALL use these register addresses relative to base_addr_p: TDFD 0x10, TLR 0x14, RDFO 0x1C, RDFD 0x20, RLR 0x24.
REQ-008 SHALL capture a TX packet into a holding register when mcl_v_i & mcl_r_o; mcl_r_o = ~tx_full.
REQ-009 SHALL write TX words to TDFD least-significant word first (word k = bits [32k+31:32k]), then write W*4 to TLR; tx_full clears on the TLR write response.
REQ-010 SHALL perform RX as follows: read RDFO; if the value is below W, return to IDLE; otherwise read RLR (value discarded), then read RDFD W times, filling words LSW first.
REQ-011 SHALL start an RX poll only when the RX output register is empty.
REQ-012 SHALL assert mcl_v_o from completion of the last RDFD read until mcl_v_o & mcl_r_i.
REQ-013 SHALL have main FSM states IDLE, WADDR, WRESP, RADDR, RDATA, and a sub-op register: TX_WORD, TX_LEN, RX_POLL, RX_LEN, RX_WORD.
REQ-014 SHALL keep at most one AXI transaction outstanding.
REQ-015 SHALL assert awvalid and wvalid together in WADDR, hold each until its own ready, then go to WRESP; bready=1 only in WRESP; leave WRESP on bvalid.
REQ-016 SHALL assert arvalid in RADDR until arready; rready=1 only in RDATA; leave RDATA on rvalid.
REQ-017 SHALL keep awaddr, wdata, and araddr stable while their valid is high; wstrb=4'hF; awprot/arprot=0.
REQ-018 SHALL, when in IDLE with a pending TX and an eligible RX at the same time, pick the op opposite to the last completed op (round-robin); after reset TX wins.
REQ-019 SHALL set error_o on bresp or rresp != 2'b00; the sequence continues and a failed-poll RDFO value is treated as 0.
REQ-020 SHALL use a word counter of width $clog2(W+1) that saturates at no point and clears on each op change.

Reset
REQ-021 SHALL, on reset_i assertion, immediately (asynchronously) force: all AXI valids and readies 0, mcl_v_o 0, mcl_r_o 0, error_o 0, FSM IDLE, tx_full 0, counters 0.
REQ-022 SHALL drive mcl_r_o = 1 on the first clk_i edge after reset_i deasserts.
REQ-023 SHALL drop any transfer that was in flight at reset and not replay it.

Structure
REQ-024 SHALL place the register offsets and the op enum in the shared package bsg_mcl_axil_pkg.
REQ-025 SHALL use the AXI-lite bus structs from the existing bsg_axi_bus_pkg macros.
REQ-026 SHALL have one sub-module, m_axil_mcl_wordbuf: an mcl_width_p-wide shift buffer that supports load-parallel/shift-out-32 and shift-in-32/read-parallel.

Verification (mcl_width_p=128, base 0x80000000)
REQ-027 SHALL cover: TX 128'h44444444_33333333_22222222_11111111 -> writes 0x80000010 with 0x11111111, 0x22222222, 0x33333333, 0x44444444, then 0x80000014 with 0x10; mcl_r_o returns to 1 after the final bvalid.
REQ-028 SHALL cover: RDFO returns 0 then 4, RDFD returns A, B, C, D -> one RLR read, four RDFD reads, mcl_data_o = {D,C,B,A}, and no RDFD read after the first poll.
REQ-029 SHALL cover: awready delayed 5 cycles with wready immediate -> wvalid low after its handshake, awvalid held, exactly one write.
REQ-030 SHALL cover: bresp=2'b10 on the second TX word -> error_o=1, remaining words and the TLR write still issued, error_o stays 1 until reset.
REQ-031 SHALL cover: mcl_r_i=0 with RX register full and TX pending -> no araddr issued and TX proceeds; with both eligible, ops alternate TX, RX, TX.
REQ-032 SHALL cover: reset_i pulsed while in RDATA -> all valids 0 in the same cycle, no mcl_v_o, and a clean TX after release.
